// File: rtl/pulse_mon_pkg.sv
// Shared types, default widths and saturating-counter helpers for the pulse train monitor.
package pulse_mon_pkg;

  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_WID_W        = 8;
  localparam int unsigned DEF_EXP_W        = 3;
  localparam int unsigned DEF_IDLE_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

  // All-ones value of a w-bit counter, carried in 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'(1) << w) - 32'(1);
  endfunction

  function automatic logic at_max(input logic [31:0] v, input int unsigned w);
    return v >= sat_max(w);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return at_max(v, w) ? v : v + 32'(1);
  endfunction

endpackage

// File: rtl/pulse_mon_edge_det.sv
// Pulse input sampling and edge detection; PULSE_MON_SYNC_EN adds a 2-flop synchronizer.
module pulse_mon_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic pulse_s,
  output logic rise_c,
  output logic fall_c
);

  logic prev_q;

`ifdef PULSE_MON_SYNC_EN
  logic [1:0] sync_q;

  // Generator runs from the LA clock mux, so resynchronise first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      pulse_s <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pulse};
      pulse_s <= sync_q[1];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_s <= 1'b0;
    else        pulse_s <= pulse;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= pulse_s;
  end

  assign rise_c = pulse_s & ~prev_q;
  assign fall_c = ~pulse_s & prev_q;

endmodule

// File: rtl/pulse_train_monitor.sv
// Counts and measures a pulse train after arming, then self-checks the count at idle timeout.
// Optional build macro: PULSE_MON_SYNC_EN (synchronized pulse input).
module pulse_train_monitor
  import pulse_mon_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned WID_W        = DEF_WID_W,
  parameter int unsigned EXP_W        = DEF_EXP_W,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             arm_i,
  input  logic [EXP_W-1:0] expected_i,
  input  logic             pulse_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             match_o,
  output logic [CNT_W-1:0] count_o,
  output logic [WID_W-1:0] min_width_o,
  output logic [WID_W-1:0] max_width_o,
  output logic [WID_W-1:0] last_gap_o,
  output logic             ovf_o
);

  logic pulse_s, rise_c, fall_c;

  pulse_mon_edge_det u_edge_det (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .pulse   (pulse_i),
    .pulse_s (pulse_s),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  state_e           state_q, state_n;
  logic             arm_q;
  logic [EXP_W-1:0] exp_q, exp_n;
  logic [WID_W-1:0] wid_q, wid_n;
  logic [WID_W-1:0] gap_q, gap_n;
  logic [CNT_W-1:0] count_n;
  logic [WID_W-1:0] min_n, max_n, last_gap_n;
  logic             busy_n, done_n, match_n, ovf_n;

  // Next state and statistics; arm_i low overrides every other event.
  always_comb begin
    state_n    = state_q;
    exp_n      = exp_q;
    wid_n      = wid_q;
    gap_n      = gap_q;
    count_n    = count_o;
    min_n      = min_width_o;
    max_n      = max_width_o;
    last_gap_n = last_gap_o;
    ovf_n      = ovf_o;
    done_n     = done_o;
    match_n    = match_o;

    if (!arm_i) begin
      state_n = ST_IDLE;
      done_n  = 1'b0;
      match_n = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!arm_q) begin
            count_n    = '0;
            min_n      = '1;
            max_n      = '0;
            last_gap_n = '0;
            ovf_n      = 1'b0;
            done_n     = 1'b0;
            match_n    = 1'b0;
            exp_n      = expected_i;
            state_n    = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rise_c) begin
            count_n = CNT_W'(sat_inc(32'(count_o), CNT_W));
            ovf_n   = ovf_o | at_max(32'(count_o), CNT_W);
            wid_n   = WID_W'(1);
            state_n = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall_c) begin
            if (wid_q < min_width_o) min_n = wid_q;
            if (wid_q > max_width_o) max_n = wid_q;
            gap_n   = WID_W'(1);
            state_n = ST_LOW;
          end else begin
            wid_n = WID_W'(sat_inc(32'(wid_q), WID_W));
            ovf_n = ovf_o | at_max(32'(wid_q), WID_W);
          end
        end
        ST_LOW: begin
          if (rise_c) begin
            count_n    = CNT_W'(sat_inc(32'(count_o), CNT_W));
            ovf_n      = ovf_o | at_max(32'(count_o), CNT_W);
            wid_n      = WID_W'(1);
            last_gap_n = gap_q;
            state_n    = ST_HIGH;
          end else if (gap_q == WID_W'(IDLE_TIMEOUT)) begin
            done_n  = 1'b1;
            match_n = (count_o == CNT_W'(exp_q)) & ~ovf_o;
            state_n = ST_DONE;
          end else begin
            gap_n = WID_W'(sat_inc(32'(gap_q), WID_W));
            ovf_n = ovf_o | at_max(32'(gap_q), WID_W);
          end
        end
        ST_DONE: ;
        default: state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n == ST_ARMED) || (state_n == ST_HIGH) || (state_n == ST_LOW);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b0;
      exp_q       <= '0;
      wid_q       <= '0;
      gap_q       <= '0;
      count_o     <= '0;
      min_width_o <= '1;
      max_width_o <= '0;
      last_gap_o  <= '0;
      ovf_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      match_o     <= 1'b0;
    end else begin
      state_q     <= state_n;
      arm_q       <= arm_i;
      exp_q       <= exp_n;
      wid_q       <= wid_n;
      gap_q       <= gap_n;
      count_o     <= count_n;
      min_width_o <= min_n;
      max_width_o <= max_n;
      last_gap_o  <= last_gap_n;
      ovf_o       <= ovf_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      match_o     <= match_n;
    end
  end

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Directed self-checking bench for pulse_train_monitor (main instance plus a 3-bit-count instance).
module tb_pulse_train_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic [2:0] expected;
  logic       pulse;

  logic       busy_o, done_o, match_o, ovf_o;
  logic [7:0] count_o, min_o, max_o, gap_o;
  logic       s_busy, s_done, s_match, s_ovf;
  logic [2:0] s_count;
  logic [7:0] s_min, s_max, s_gap;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Edges from driving the last low level to done_o being visible, minus the one already ticked.
`ifdef PULSE_MON_SYNC_EN
  localparam int DONE_LAT = 11;
`else
  localparam int DONE_LAT = 9;
`endif

  always #5 clk = ~clk;

  pulse_train_monitor #(.CNT_W(8), .WID_W(8), .EXP_W(3), .IDLE_TIMEOUT(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .arm_i(arm), .expected_i(expected), .pulse_i(pulse),
    .busy_o(busy_o), .done_o(done_o), .match_o(match_o), .count_o(count_o),
    .min_width_o(min_o), .max_width_o(max_o), .last_gap_o(gap_o), .ovf_o(ovf_o)
  );

  pulse_train_monitor #(.CNT_W(3), .WID_W(8), .EXP_W(3), .IDLE_TIMEOUT(8)) u_small (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .arm_i(arm), .expected_i(expected), .pulse_i(pulse),
    .busy_o(s_busy), .done_o(s_done), .match_o(s_match), .count_o(s_count),
    .min_width_o(s_min), .max_width_o(s_max), .last_gap_o(s_gap), .ovf_o(s_ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input int w, input int g);
    pulse = 1'b1; tick(w);
    pulse = 1'b0; tick(g);
  endtask

  task automatic rearm(input logic [2:0] e);
    arm = 1'b0; tick(2);
    expected = e; arm = 1'b1; tick(2);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done_o && c < 400) begin tick(1); c++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; arm = 1'b0; expected = 3'd0; pulse = 1'b0;
    tick(3);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0d want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0d want 0", done_o); end
    n_cmp++; if (count_o !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (min_o !== 8'hFF) begin n_bad++; $display("FAIL reset_min got %0h want ff", min_o); end
    n_cmp++; if ({match_o, ovf_o, max_o, gap_o} !== 18'd0) begin n_bad++; $display("FAIL reset_misc got %0h want 0", {match_o, ovf_o, max_o, gap_o}); end
    rst_n = 1'b1; tick(2);
  endtask

  task automatic test_generator_train;
    rearm(3'd5);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL gen_armed_busy got %0d want 1", busy_o); end
    for (int i = 0; i < 5; i++) drive_pulse(1, 1);
    wait_done(cyc);
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL gen_done_timeout got %0d want 1", done_o); end
    n_cmp++; if (cyc !== DONE_LAT) begin n_bad++; $display("FAIL gen_done_latency got %0d want %0d", cyc, DONE_LAT); end
    n_cmp++; if (count_o !== 8'd5) begin n_bad++; $display("FAIL gen_count got %0d want 5", count_o); end
    n_cmp++; if (min_o !== 8'd1 || max_o !== 8'd1) begin n_bad++; $display("FAIL gen_minmax got %0d/%0d want 1/1", min_o, max_o); end
    n_cmp++; if (gap_o !== 8'd1) begin n_bad++; $display("FAIL gen_gap got %0d want 1", gap_o); end
    n_cmp++; if (match_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL gen_match_busy got %0d/%0d want 1/0", match_o, busy_o); end
  endtask

  task automatic test_mismatch;
    rearm(3'd3);
    for (int i = 0; i < 4; i++) drive_pulse(3, 2);
    wait_done(cyc);
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL mis_done_timeout got %0d want 1", done_o); end
    n_cmp++; if (count_o !== 8'd4) begin n_bad++; $display("FAIL mis_count got %0d want 4", count_o); end
    n_cmp++; if (min_o !== 8'd3 || max_o !== 8'd3) begin n_bad++; $display("FAIL mis_minmax got %0d/%0d want 3/3", min_o, max_o); end
    n_cmp++; if (gap_o !== 8'd2) begin n_bad++; $display("FAIL mis_gap got %0d want 2", gap_o); end
    n_cmp++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL mis_match got %0d want 0", match_o); end
  endtask

  // Gaps of 7 and exactly the timeout (8) followed by a rise must keep the train alive.
  task automatic test_width_spread;
    rearm(3'd4);
    drive_pulse(2, 3);
    drive_pulse(5, 7);
    drive_pulse(1, 8);
    pulse = 1'b1; tick(3);
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL spread_alive got done=%0d busy=%0d want 0/1", done_o, busy_o); end
    pulse = 1'b0; tick(1);
    wait_done(cyc);
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL spread_done_timeout got %0d want 1", done_o); end
    n_cmp++; if (count_o !== 8'd4) begin n_bad++; $display("FAIL spread_count got %0d want 4", count_o); end
    n_cmp++; if (min_o !== 8'd1 || max_o !== 8'd5) begin n_bad++; $display("FAIL spread_minmax got %0d/%0d want 1/5", min_o, max_o); end
    n_cmp++; if (gap_o !== 8'd8) begin n_bad++; $display("FAIL spread_gap got %0d want 8", gap_o); end
    n_cmp++; if (match_o !== 1'b1) begin n_bad++; $display("FAIL spread_match got %0d want 1", match_o); end
  endtask

  task automatic test_pre_high;
    arm = 1'b0; pulse = 1'b1; tick(4);
    expected = 3'd2; arm = 1'b1; tick(3);
    pulse = 1'b0; tick(2);
    drive_pulse(2, 2);
    drive_pulse(2, 2);
    wait_done(cyc);
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL prehigh_done_timeout got %0d want 1", done_o); end
    n_cmp++; if (count_o !== 8'd2) begin n_bad++; $display("FAIL prehigh_count got %0d want 2", count_o); end
    n_cmp++; if (match_o !== 1'b1) begin n_bad++; $display("FAIL prehigh_match got %0d want 1", match_o); end
  endtask

  task automatic test_overflow;
    rearm(3'd7);
    for (int i = 0; i < 9; i++) drive_pulse(1, 1);
    wait_done(cyc);
    n_cmp++; if (s_done !== 1'b1) begin n_bad++; $display("FAIL ovf_small_done got %0d want 1", s_done); end
    n_cmp++; if (s_count !== 3'd7) begin n_bad++; $display("FAIL ovf_small_count got %0d want 7", s_count); end
    n_cmp++; if (s_ovf !== 1'b1 || s_match !== 1'b0) begin n_bad++; $display("FAIL ovf_small_flags got ovf=%0d match=%0d want 1/0", s_ovf, s_match); end
    n_cmp++; if (count_o !== 8'd9 || ovf_o !== 1'b0) begin n_bad++; $display("FAIL ovf_main_count got %0d ovf=%0d want 9/0", count_o, ovf_o); end
    rearm(3'd1);
    drive_pulse(300, 2);
    wait_done(cyc);
    n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL long_done_timeout got %0d want 1", done_o); end
    n_cmp++; if (max_o !== 8'd255 || min_o !== 8'd255) begin n_bad++; $display("FAIL long_width got %0d/%0d want 255/255", min_o, max_o); end
    n_cmp++; if (ovf_o !== 1'b1 || count_o !== 8'd1) begin n_bad++; $display("FAIL long_ovf got ovf=%0d count=%0d want 1/1", ovf_o, count_o); end
    n_cmp++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL long_match got %0d want 0", match_o); end
  endtask

  task automatic test_reset_mid;
    rearm(3'd2);
    drive_pulse(2, 2);
    pulse = 1'b1; tick(4);
    #2 rst_n = 1'b0; arm = 1'b0;
    #1;
    n_cmp++; if (count_o !== 8'd0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_count_busy got %0d/%0d want 0/0", count_o, busy_o); end
    n_cmp++; if (min_o !== 8'hFF || max_o !== 8'd0 || gap_o !== 8'd0) begin n_bad++; $display("FAIL rstmid_stats got %0h/%0h/%0h want ff/0/0", min_o, max_o, gap_o); end
    pulse = 1'b0; tick(1);
    rst_n = 1'b1; tick(2);
  endtask

  task automatic test_disarm;
    rearm(3'd2);
    drive_pulse(2, 2);
    drive_pulse(2, 2);
    pulse = 1'b1; tick(2);
    arm = 1'b0; tick(1);
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_bad++; $display("FAIL disarm_state got busy=%0d done=%0d want 0/0", busy_o, done_o); end
    pulse = 1'b0; tick(4);
    drive_pulse(1, 1);
    n_cmp++; if (count_o !== 8'd3) begin n_bad++; $display("FAIL disarm_count_held got %0d want 3", count_o); end
    n_cmp++; if (min_o !== 8'd2 || max_o !== 8'd2 || gap_o !== 8'd2) begin n_bad++; $display("FAIL disarm_stats_held got %0d/%0d/%0d want 2/2/2", min_o, max_o, gap_o); end
  endtask

  initial begin
    test_reset();
    test_generator_train();
    test_mismatch();
    test_width_spread();
    test_pre_high();
    test_overflow();
    test_reset_mid();
    test_disarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_monitor.md
Name: pulse_train_monitor

Overview:
- Downstream consumer of the LA-driven pulse generator: samples its pulse output, counts rising edges, measures high width and low gap, and declares the train finished after an idle timeout.
- Compares the final count against the expected count programmed over the LA bus and raises `match_o` / `done_o`, so the logic analyzer can self-check the generator in silicon.

Parameters:
- `CNT_W`, 8: pulse-count width; count saturates at 2^CNT_W-1.
- `WID_W`, 8: width/gap measurement width; saturating.
- `EXP_W`, 3: expected-count width, matching the generator's pulse-count field.
- `IDLE_TIMEOUT`, 16: consecutive low cycles after at least one pulse that end the train; legal range 1..2^WID_W-1.

Ports:
- `wb_clk_i`, in, 1: single clock; all logic on its rising edge.
- `wb_rst_i`, in, 1: reset; asynchronous assert, active-low (0 = reset); deassert synchronous to `wb_clk_i`.
- `arm_i`, in, 1: level; rising edge clears statistics and starts monitoring; low returns to IDLE.
- `expected_i`, in, EXP_W: expected pulse count; captured on the arm rising edge.
- `pulse_i`, in, 1: pulse train from the generator.
- `busy_o`, out, 1: high in ARMED / HIGH / LOW.
- `done_o`, out, 1: high in DONE.
- `match_o`, out, 1: valid while `done_o`; count equals captured expected (zero-extended) and no overflow.
- `count_o`, out, CNT_W: rising edges seen since arm.
- `min_width_o`, out, WID_W: shortest high width seen (cycles).
- `max_width_o`, out, WID_W: longest high width seen.
- `last_gap_o`, out, WID_W: low cycles between the last two pulses.
- `ovf_o`, out, 1: sticky; count or any width/gap counter saturated.

Behaviour:
- **Reset:**
  - All outputs 0 except `min_width_o`, which resets to all-ones.
  - State IDLE; edge-detect history cleared to 0.
- **Input path:**
  - `pulse_s` is the registered `pulse_i`, giving 1 cycle of latency.
  - rise = `pulse_s` & ~prev; fall = ~`pulse_s` & prev.
- **IDLE:**
  - On arm rising edge: clear `count_o`, `max_width_o`, `last_gap_o`, `ovf_o`, `done_o`, `match_o`; set `min_width_o` to all-ones; capture `expected_i`; go to ARMED.
- **ARMED:**
  - Wait for a rise. A pulse already high at arm time is ignored until it falls and rises again.
  - No timeout while no pulse has been seen.
- **Rise (ARMED or LOW) → HIGH:**
  - `count_o` increments, saturating; saturation sets `ovf_o`.
  - Width counter loads 1.
  - From LOW only: `last_gap_o` takes the gap counter value.
- **HIGH:**
  - Width counter increments each cycle `pulse_s` stays high (saturating, sets `ovf_o`).
  - On fall: update min/max with the final width, clear the gap counter to 1, go to LOW.
  - A single-cycle pulse records width 1.
- **LOW:**
  - Gap counter increments each low cycle (saturating).
  - Rise → HIGH.
  - Gap counter == `IDLE_TIMEOUT` → DONE.
- **DONE:**
  - `done_o` = 1; `match_o` = (`count_o` == expected) & ~`ovf_o`.
  - Stats frozen; further pulses ignored.
- **arm_i low:**
  - From any state, go to IDLE at the next edge; stats are held for readout and `done_o` clears.
  - Re-arm requires a new rising edge of `arm_i`.
- **Simultaneous events:**
  - Rise on the cycle the gap reaches the timeout: the rise wins, stay in the train.
  - `arm_i` fall beats every other event.
- **Reset mid-operation:** immediate return to reset values; no partial results are retained.

Optional Feature:
- Macro `PULSE_MON_SYNC_EN`.
- **When defined:** `pulse_i` passes through a 2-flop synchronizer before `pulse_s`, for a generator clocked from the LA clock mux. Input latency becomes 3 cycles; all reported values are unchanged.
- **When undefined:** single register only (same-clock source).

Decomposition:
- Shared package `pulse_mon_pkg`:
  - state enum IDLE/ARMED/HIGH/LOW/DONE;
  - default width constants;
  - saturating-increment function.
- One sub-module, `pulse_mon_edge_det`:
  - optional synchronizer (`PULSE_MON_SYNC_EN`) plus the registered sample;
  - outputs `pulse_s`, rise, fall.
- The FSM and statistics stay in the top module.

Test Plan:
- **Generator-style train:** IDLE_TIMEOUT=8, arm with expected=5; 5 pulses of width 1, gap 1 → `count_o`=5, min=max=1, `last_gap_o`=1. `done_o` rises 8 cycles after the last fall (plus input latency); `match_o`=1.
- **Mismatch:** expected=3; 4 pulses of width 3, gap 2 → `count_o`=4, min=max=3, `match_o`=0.
- **Width spread:** widths 2, 5, 1 → min=1, max=5. Gap of exactly 7 then a rise with TIMEOUT=8 → no DONE, count continues.
- **Pre-high at arm:** `pulse_i` already high at arm, falls, then 2 pulses → `count_o`=2.
- **Overflow:** CNT_W=3, 9 pulses → `count_o`=7, `ovf_o`=1, `match_o`=0. A 300-cycle pulse with WID_W=8 → `max_width_o`=255, `ovf_o`=1.
- **Reset/disarm:** `wb_rst_i` low mid-HIGH → all outputs reset asynchronously, `min_width_o` all-ones. `arm_i` dropped mid-train → IDLE, stats held, `done_o`=0.
